// File: rtl/addsub_share_arb.sv
// Two-requester round-robin front end for one shared 16-bit carry-lookahead add/sub unit,
// with a registered tagged response, signed-overflow detection/saturation and an event counter.
module addsub_share_arb #(
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [15:0]      rsp_sum,
    output logic             rsp_ovfl,
    output logic [CNT_W-1:0] ovfl_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic [15:0]        sum_q, sum_d;
    logic               ovfl_q, ovfl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               can_accept, grant0, grant1, accept;
    logic [15:0]        op_a, op_b, b_eff, gen, prop, add_sum, result;
    logic               op_sub, ovfl, adder_err;
    logic [16:0]        carry;

    // Arbitration: a lone requester wins; on contention the pointer decides.
    assign can_accept = (state_q == StEmpty) | rsp_ready;
    assign grant0     = req0_valid & (~req1_valid | ~ptr_q);
    assign grant1     = req1_valid & (~req0_valid | ptr_q);
    assign req0_ready = rst_n & can_accept & grant0;
    assign req1_ready = rst_n & can_accept & grant1;
    assign accept     = req0_ready | req1_ready;

    assign op_a   = grant1 ? req1_a   : req0_a;
    assign op_b   = grant1 ? req1_b   : req0_b;
    assign op_sub = grant1 ? req1_sub : req0_sub;

    // Shared adder: 4-bit groups, group carries by lookahead, subtraction as A + ~B + 1.
    assign b_eff = op_b ^ {16{op_sub}};
    assign gen   = op_a & b_eff;
    assign prop  = op_a ^ b_eff;

    always_comb begin
        logic grp_g, grp_p;
        carry    = '0;
        carry[0] = op_sub;
        for (int grp = 0; grp < 4; grp++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                carry[4*grp+j+1] = gen[4*grp+j] | (prop[4*grp+j] & carry[4*grp+j]);
                grp_g = gen[4*grp+j] | (prop[4*grp+j] & grp_g);
                grp_p = grp_p & prop[4*grp+j];
            end
            carry[4*grp+4] = grp_g | (grp_p & carry[4*grp]);
        end
    end

    assign add_sum   = prop ^ carry[15:0];
    assign adder_err = carry[16] ^ carry[15];

    always_comb begin
        ovfl = 1'b0;
        if (op_sub) ovfl = (op_a[15] != op_b[15]) && (add_sum[15] != op_a[15]);
        else        ovfl = (op_a[15] == op_b[15]) && (add_sum[15] != op_a[15]);
    end

    assign result = (SATURATE && ovfl) ? (op_a[15] ? 16'h8000 : 16'h7FFF) : add_sum;

    always_ff @(posedge clk) begin
        if (rst_n && accept) assert (ovfl == adder_err);
    end

    // Response FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (rsp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == StFull);
    end

    // Datapath and counter
    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        sum_d  = sum_q;
        ovfl_d = ovfl_q;
        cnt_d  = cnt_q;
        if (accept) begin
            ptr_d  = ~grant1;
            id_d   = grant1;
            sum_d  = result;
            ovfl_d = ovfl;
            if (ovfl && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            id_q   <= 1'b0;
            sum_q  <= 16'h0000;
            ovfl_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            sum_q  <= sum_d;
            ovfl_q <= ovfl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_ovfl = ovfl_q;
    assign ovfl_cnt = cnt_q;

endmodule

// File: tb/tb_addsub_share_arb.sv
// Randomized and directed bench for addsub_share_arb; wrapping and saturating instances share
// stimulus and are checked against an arithmetic reference model.
module tb_addsub_share_arb;

    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r0v = 1'b0, r0s = 1'b0, r1v = 1'b0, r1s = 1'b0, rr = 1'b0;
    logic [15:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;

    logic w_rdy0, w_rdy1, w_valid, w_id, w_ovfl;
    logic [15:0] w_sum;
    logic [CNT_W-1:0] w_cnt;
    logic s_rdy0, s_rdy1, s_valid, s_id, s_ovfl;
    logic [15:0] s_sum;
    logic [CNT_W-1:0] s_cnt;

    always #5 clk = ~clk;

    addsub_share_arb #(.SATURATE(1'b0), .CNT_W(CNT_W)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(w_rdy0), .req0_a(r0a), .req0_b(r0b), .req0_sub(r0s),
        .req1_valid(r1v), .req1_ready(w_rdy1), .req1_a(r1a), .req1_b(r1b), .req1_sub(r1s),
        .rsp_valid(w_valid), .rsp_ready(rr), .rsp_id(w_id), .rsp_sum(w_sum),
        .rsp_ovfl(w_ovfl), .ovfl_cnt(w_cnt)
    );

    addsub_share_arb #(.SATURATE(1'b1), .CNT_W(CNT_W)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(s_rdy0), .req0_a(r0a), .req0_b(r0b), .req0_sub(r0s),
        .req1_valid(r1v), .req1_ready(s_rdy1), .req1_a(r1a), .req1_b(r1b), .req1_sub(r1s),
        .rsp_valid(s_valid), .rsp_ready(rr), .rsp_id(s_id), .rsp_sum(s_sum),
        .rsp_ovfl(s_ovfl), .ovfl_cnt(s_cnt)
    );

    int n_checks = 0;
    int n_errs = 0;

    // Reference model state
    bit          m_valid, m_id, m_ovfl, m_ptr;
    logic [15:0] m_wrap, m_sat;
    int          m_cnt;
    bit          e0, e1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compute(input logic [15:0] a, input logic [15:0] b, input bit sub,
                           output logic [15:0] wrap, output logic [15:0] sat, output bit ov);
        int r;
        r = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
        ov = (r > 32767) || (r < -32768);
        wrap = r[15:0];
        sat = ov ? ((r > 0) ? 16'h7FFF : 16'h8000) : wrap;
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_ovfl = 0; m_ptr = 0; m_cnt = 0;
        m_wrap = '0; m_sat = '0; e0 = 0; e1 = 0;
    endtask

    task automatic check_outputs();
        check_eq("wrap_valid", {31'b0, w_valid}, {31'b0, m_valid});
        check_eq("sat_valid", {31'b0, s_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check_eq("wrap_id", {31'b0, w_id}, {31'b0, m_id});
            check_eq("wrap_sum", {16'b0, w_sum}, {16'b0, m_wrap});
            check_eq("wrap_ovfl", {31'b0, w_ovfl}, {31'b0, m_ovfl});
            check_eq("sat_id", {31'b0, s_id}, {31'b0, m_id});
            check_eq("sat_sum", {16'b0, s_sum}, {16'b0, m_sat});
            check_eq("sat_ovfl", {31'b0, s_ovfl}, {31'b0, m_ovfl});
        end
        check_eq("wrap_cnt", 32'(w_cnt), 32'(m_cnt));
        check_eq("sat_cnt", 32'(s_cnt), 32'(m_cnt));
    endtask

    // Inputs are already set; check readies, clock once, update model, check response.
    task automatic step();
        bit can;
        logic [15:0] wr, sa;
        bit ov;
        can = !m_valid || rr;
        e0 = can && r0v && (!r1v || !m_ptr);
        e1 = can && r1v && (!r0v || m_ptr);
        #1;
        check_eq("wrap_rdy0", {31'b0, w_rdy0}, {31'b0, e0});
        check_eq("wrap_rdy1", {31'b0, w_rdy1}, {31'b0, e1});
        check_eq("sat_rdy0", {31'b0, s_rdy0}, {31'b0, e0});
        check_eq("sat_rdy1", {31'b0, s_rdy1}, {31'b0, e1});
        @(posedge clk);
        if (e0 || e1) begin
            if (e1) compute(r1a, r1b, r1s, wr, sa, ov);
            else    compute(r0a, r0b, r0s, wr, sa, ov);
            m_valid = 1; m_id = e1; m_wrap = wr; m_sat = sa; m_ovfl = ov;
            m_ptr = !e1;
            if (ov && m_cnt < CNT_MAX) m_cnt++;
        end else if (can) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic set_req(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                           input bit s0, input bit v1, input logic [15:0] a1,
                           input logic [15:0] b1, input bit s1, input bit ready);
        r0v = v0; r0a = a0; r0b = b0; r0s = s0;
        r1v = v1; r1a = a1; r1b = b1; r1s = s1;
        rr = ready;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0001;
            3: return 16'hFFFF;
            4: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid", {31'b0, w_valid}, 32'd0);
        check_eq("rst_cnt", 32'(w_cnt), 32'd0);
        check_eq("rst_sat_cnt", 32'(s_cnt), 32'd0);
        check_eq("rst_rdy0", {31'b0, w_rdy0}, 32'd0);
        check_eq("rst_rdy1", {31'b0, w_rdy1}, 32'd0);
        check_eq("rst_id", {31'b0, w_id}, 32'd0);
        check_eq("rst_sum", {16'b0, w_sum}, 32'd0);
        check_eq("rst_ovfl", {31'b0, w_ovfl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_eq("init_valid", {31'b0, w_valid}, 32'd0);
        check_eq("init_cnt", 32'(w_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add
        set_req(1, 16'h1234, 16'h0001, 0, 0, 0, 0, 0, 1);
        step();
        check_eq("add_sum", {16'b0, w_sum}, 32'h1235);
        check_eq("add_id", {31'b0, w_id}, 32'd0);

        // Overflow in both directions
        set_req(1, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 0, 1);
        step();
        check_eq("povf_wrap", {16'b0, w_sum}, 32'h8000);
        check_eq("povf_sat", {16'b0, s_sum}, 32'h7FFF);
        check_eq("povf_cnt", 32'(w_cnt), 32'd1);
        set_req(0, 0, 0, 0, 1, 16'h8000, 16'h0001, 1, 1);
        step();
        check_eq("novf_wrap", {16'b0, w_sum}, 32'h7FFF);
        check_eq("novf_sat", {16'b0, s_sum}, 32'h8000);
        check_eq("novf_id", {31'b0, w_id}, 32'd1);

        // Contention, one response per cycle, alternating ids
        set_req(1, 16'h0100, 16'h0023, 0, 1, 16'h0500, 16'h0007, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rr_id", {31'b0, w_id}, 32'(i % 2));
        end

        // Backpressure then simultaneous drain and accept
        rr = 0;
        for (int i = 0; i < 3; i++) step();
        rr = 1;
        step();

        // Build cnt=5 while FULL, then reset mid-operation
        set_req(1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step();
        check_eq("pre_rst_cnt", 32'(w_cnt), 32'd5);
        reset_now();
        set_req(1, 16'h0002, 16'h0003, 0, 1, 16'h0010, 16'h0001, 0, 1);
        step();
        check_eq("post_rst_grant", {31'b0, w_id}, 32'd0);

        // Randomized traffic honouring the hold-while-stalled rule
        for (int i = 0; i < 500; i++) begin
            if (!(r0v && !e0)) begin
                r0v = ($urandom_range(0, 3) != 0); r0a = pick(); r0b = pick(); r0s = 1'($urandom);
            end
            if (!(r1v && !e1)) begin
                r1v = ($urandom_range(0, 3) != 0); r1a = pick(); r1b = pick(); r1s = 1'($urandom);
            end
            rr = ($urandom_range(0, 3) != 0);
            step();
        end

        // Counter saturation
        reset_now();
        set_req(1, 16'h8000, 16'h0001, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step();
        check_eq("cnt_sat", 32'(w_cnt), 32'hFF);
        set_req(1, 16'h0004, 16'h0001, 1, 0, 0, 0, 0, 1);
        step();
        check_eq("cnt_hold", 32'(w_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
